// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } dcache_state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int sets, input int line_words);
        return ADDR_W - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Flop-based line storage: valid/dirty/tag/data with a combinational lookup port,
// a single-word store port and a whole-line refill port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [$clog2(SETS)-1:0]                       rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0]                 rd_off,
    output logic                                          rd_valid,
    output logic                                          rd_dirty,
    output logic [30-$clog2(SETS)-$clog2(LINE_WORDS)-1:0] rd_tag,
    output logic [31:0]                                   rd_word,
    output logic [32*LINE_WORDS-1:0]                      rd_line,
    input  logic                                          wr_en,
    input  logic [$clog2(SETS)-1:0]                       wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0]                 wr_off,
    input  logic [31:0]                                   wr_data,
    input  logic                                          fill_en,
    input  logic [$clog2(SETS)-1:0]                       fill_idx,
    input  logic [30-$clog2(SETS)-$clog2(LINE_WORDS)-1:0] fill_tag,
    input  logic [32*LINE_WORDS-1:0]                      fill_line
);

    localparam int TAG_W  = tag_bits(SETS, LINE_WORDS);
    localparam int LINE_W = WORD_W * LINE_WORDS;

    logic [SETS-1:0]   valid_r;
    logic [SETS-1:0]   dirty_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [LINE_W-1:0] data_r [SETS];

    // Combinational lookup of the addressed line and word.
    always_comb begin
        rd_valid = valid_r[rd_idx];
        rd_dirty = dirty_r[rd_idx];
        rd_tag   = tag_r[rd_idx];
        rd_line  = data_r[rd_idx];
        rd_word  = data_r[rd_idx][WORD_W*int'(rd_off) +: WORD_W];
    end

    // Line state bits: a refill installs a clean line, a store marks it dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {SETS{1'b0}};
            dirty_r <= {SETS{1'b0}};
        end else if (fill_en) begin
            valid_r[fill_idx] <= 1'b1;
            dirty_r[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload; deliberately left without reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[fill_idx]  <= fill_tag;
            data_r[fill_idx] <= fill_line;
        end else if (wr_en) begin
            data_r[wr_idx][WORD_W*int'(wr_off) +: WORD_W] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               d_addr,
    input  logic                      d_rd,
    input  logic                      d_wr,
    input  logic [31:0]               d_wr_data,
    output logic [31:0]               d_rd_data,
    output logic                      d_miss,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [32*LINE_WORDS-1:0]  mem_wdata,
    input  logic [32*LINE_WORDS-1:0]  mem_rdata,
    input  logic                      mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    localparam int OFF_W  = off_bits(LINE_WORDS);
    localparam int IDX_W  = idx_bits(SETS);
    localparam int TAG_W  = tag_bits(SETS, LINE_WORDS);
    localparam int LINE_W = WORD_W * LINE_WORDS;

    dcache_state_t     state_r;
    logic [TAG_W-1:0]  req_tag_r;
    logic [IDX_W-1:0]  req_idx_r;

    logic [OFF_W-1:0]  addr_off_s;
    logic [IDX_W-1:0]  addr_idx_s;
    logic [TAG_W-1:0]  addr_tag_s;
    logic              lk_valid_s;
    logic              lk_dirty_s;
    logic [TAG_W-1:0]  lk_tag_s;
    logic [31:0]       lk_word_s;
    logic [LINE_W-1:0] lk_line_s;

    logic req_s;
    logic idle_s;
    logic hit_s;
    logic service_s;
    logic wr_en_s;
    logic fill_en_s;
    logic addr_unused_s;

    assign addr_off_s    = d_addr[OFF_W+1:2];
    assign addr_idx_s    = d_addr[OFF_W+2 +: IDX_W];
    assign addr_tag_s    = d_addr[ADDR_W-1 -: TAG_W];
    assign addr_unused_s = ^d_addr[1:0];

    assign req_s     = d_rd | d_wr;
    assign idle_s    = (state_r == IDLE);
    assign hit_s     = lk_valid_s & (lk_tag_s == addr_tag_s);
    assign service_s = req_s & idle_s & hit_s;
    assign d_miss    = req_s & ~(idle_s & hit_s);
    // A simultaneous read and write is treated as a write.
    assign wr_en_s   = service_s & d_wr;
    assign fill_en_s = (state_r == REFILL) & mem_ack;

    dcache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (addr_idx_s),
        .rd_off    (addr_off_s),
        .rd_valid  (lk_valid_s),
        .rd_dirty  (lk_dirty_s),
        .rd_tag    (lk_tag_s),
        .rd_word   (lk_word_s),
        .rd_line   (lk_line_s),
        .wr_en     (wr_en_s),
        .wr_idx    (addr_idx_s),
        .wr_off    (addr_off_s),
        .wr_data   (d_wr_data),
        .fill_en   (fill_en_s),
        .fill_idx  (req_idx_r),
        .fill_tag  (req_tag_r),
        .fill_line (mem_rdata)
    );

    // Load data is driven only on a serviced read, zero otherwise.
    always_comb begin
        if (service_s & d_rd & ~d_wr) begin
            d_rd_data = lk_word_s;
        end else begin
            d_rd_data = 32'h0000_0000;
        end
    end

    // Miss FSM with registered backing-memory request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= MEM_RD;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= {LINE_W{1'b0}};
            req_tag_r <= {TAG_W{1'b0}};
            req_idx_r <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s & ~hit_s) begin
                        req_tag_r <= addr_tag_s;
                        req_idx_r <= addr_idx_s;
                        mem_req   <= 1'b1;
                        if (lk_valid_s & lk_dirty_s) begin
                            state_r   <= WB;
                            mem_we    <= MEM_WR;
                            mem_addr  <= {lk_tag_s, addr_idx_s, {(OFF_W+2){1'b0}}};
                            mem_wdata <= lk_line_s;
                        end else begin
                            state_r  <= REFILL;
                            mem_we   <= MEM_RD;
                            mem_addr <= {addr_tag_s, addr_idx_s, {(OFF_W+2){1'b0}}};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WB: begin
                    // mem_req stays high; only direction and address move to the refill.
                    if (mem_ack) begin
                        state_r  <= REFILL;
                        mem_we   <= MEM_RD;
                        mem_addr <= {req_tag_r, req_idx_r, {(OFF_W+2){1'b0}}};
                    end else begin
                        state_r <= WB;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        state_r <= IDLE;
                        mem_req <= 1'b0;
                    end else begin
                        state_r <= REFILL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= MEM_RD;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic returned_r;

    // Hit/miss counters; the replayed request right after a refill is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt    <= 32'h0000_0000;
            miss_cnt   <= 32'h0000_0000;
            returned_r <= 1'b0;
        end else begin
            returned_r <= fill_en_s;
            if (service_s & ~returned_r) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                hit_cnt <= hit_cnt;
            end
            if (idle_s & req_s & ~hit_s) begin
                miss_cnt <= miss_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt;
            end
        end
    end
`endif

endmodule
